// File: rtl/mdic_ctrl.sv
// mdic_ctrl: host-side controller for the MAC MDI Control (MDIC) register.
//
// A software write to MDIC is turned into a 32-bit clause-22 MDIO frame and
// handed to the downstream MDIO shift engine with a one-cycle start pulse. The
// controller then follows the engine's done handshake and writes the outcome
// back into MDIC (read data, Ready, Error), optionally raising an interrupt.
//
// Ports:
//   clk        clock
//   rst        asynchronous, active-high reset
//   reg_wr     one-cycle MDIC write strobe from the register file
//   reg_wdata  MDIC write data: [15:0] DATA, [20:16] REGADD, [25:21] PHYADD,
//              [27:26] OP, [29] I
//   reg_rdata  current MDIC value: [15:0] DATA, [20:16] REGADD, [25:21] PHYADD,
//              [27:26] OP, [28] R, [29] I, [30] E, [31] 0
//   intr_o     one-cycle MDAC interrupt request
//   eno        one-cycle start pulse to the shift engine
//   wdatao     MDIO frame to the shift engine (valid while eno is high)
//   rdatai     read data from the shift engine (valid whenever rd_donei is 1)
//   rd_donei   engine read done; low while a read runs
//   wr_donei   engine write done; low while a write runs
//
// Parameters:
//   TIMEOUT    cycles from issue to completion before the operation is aborted
//   TW         width of the timeout counter; 2**TW must exceed TIMEOUT

module mdic_ctrl #(
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned TW      = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_wr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  output logic        intr_o,
  output logic        eno,
  output logic [31:0] wdatao,
  input  logic [15:0] rdatai,
  input  logic        rd_donei,
  input  logic        wr_donei
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StIssue    = 3'd1;
  localparam logic [2:0] StWaitBusy = 3'd2;
  localparam logic [2:0] StWaitDone = 3'd3;
  localparam logic [2:0] StComplete = 3'd4;

  localparam logic [1:0] OpWrite = 2'b01;
  localparam logic [1:0] OpRead  = 2'b10;

  localparam logic [TW-1:0] TimeoutLast = TW'(TIMEOUT - 1);

  // Register state
  logic [2:0]    state_q, state_d;
  logic [15:0]   data_q, data_d;
  logic [4:0]    regadd_q, regadd_d;
  logic [4:0]    phyadd_q, phyadd_d;
  logic [1:0]    op_q, op_d;
  logic          ien_q, ien_d;
  logic          rdy_q, rdy_d;
  logic          err_q, err_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          eno_q, eno_d;
  logic [31:0]   frame_q, frame_d;
  logic          intr_q, intr_d;

  // Helper signals
  logic          accept;
  logic          op_valid;
  logic [1:0]    wr_op;
  logic          sel_done;
  logic [TW-1:0] cnt_inc;
  logic          timeout;

  // Bits of the write data that MDIC does not store (R and E are status only).
  logic unused_wdata;
  assign unused_wdata = ^{reg_wdata[31:30], reg_wdata[28]};

  // A command is only taken while the engine reports itself idle on both done
  // lines; this also covers an engine still finishing a frame after a reset or
  // a timeout.
  assign accept   = reg_wr && rd_donei && wr_donei;
  assign wr_op    = reg_wdata[27:26];
  assign op_valid = (wr_op == OpRead) || (wr_op == OpWrite);

  // The latched opcode picks which done line carries the handshake.
  assign sel_done = (op_q == OpRead) ? rd_donei : wr_donei;

  // Abort when the counter would reach TIMEOUT-1 on this edge.
  assign cnt_inc  = cnt_q + TW'(1);
  assign timeout  = (cnt_inc == TimeoutLast);

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    regadd_d = regadd_q;
    phyadd_d = phyadd_q;
    op_d     = op_q;
    ien_d    = ien_q;
    rdy_d    = rdy_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    eno_d    = 1'b0;
    frame_d  = frame_q;
    intr_d   = 1'b0;

    case (state_q)
      StIdle: begin
        if (accept) begin
          data_d   = reg_wdata[15:0];
          regadd_d = reg_wdata[20:16];
          phyadd_d = reg_wdata[25:21];
          op_d     = wr_op;
          ien_d    = reg_wdata[29];
          rdy_d    = 1'b0;
          err_d    = 1'b0;
          if (op_valid) begin
            // Frame is built straight from the write data so eno and wdatao
            // line up in the cycle after the accept.
            eno_d   = 1'b1;
            frame_d = {2'b01, wr_op, reg_wdata[25:21], reg_wdata[20:16], 2'b10,
                       (wr_op == OpRead) ? 16'h0000 : reg_wdata[15:0]};
            state_d = StIssue;
          end else begin
            err_d   = 1'b1;
            state_d = StComplete;
          end
        end
      end

      StIssue: begin
        cnt_d   = '0;
        state_d = StWaitBusy;
      end

      StWaitBusy: begin
        cnt_d = cnt_inc;
        if (timeout) begin
          err_d   = 1'b1;
          state_d = StComplete;
        end else if (!sel_done) begin
          state_d = StWaitDone;
        end
      end

      StWaitDone: begin
        cnt_d = cnt_inc;
        // A finishing engine wins over a simultaneous timeout.
        if (sel_done) begin
          if (op_q == OpRead) begin
            data_d = rdatai;
          end
          state_d = StComplete;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = StComplete;
        end
      end

      StComplete: begin
        rdy_d   = 1'b1;
        intr_d  = ien_q;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      data_q   <= '0;
      regadd_q <= '0;
      phyadd_q <= '0;
      op_q     <= '0;
      ien_q    <= 1'b0;
      rdy_q    <= 1'b1;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      eno_q    <= 1'b0;
      frame_q  <= '0;
      intr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      regadd_q <= regadd_d;
      phyadd_q <= phyadd_d;
      op_q     <= op_d;
      ien_q    <= ien_d;
      rdy_q    <= rdy_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      eno_q    <= eno_d;
      frame_q  <= frame_d;
      intr_q   <= intr_d;
    end
  end

  assign reg_rdata = {1'b0, err_q, ien_q, rdy_q, op_q, phyadd_q, regadd_q, data_q};
  assign intr_o    = intr_q;
  assign eno       = eno_q;
  assign wdatao    = frame_q;

endmodule

// File: doc/mdic_ctrl.md
Name: mdic_ctrl

Overview:
- Host-side controller for the MAC MDI Control (MDIC) register.
- Turns a software MDIC write into a 32-bit IEEE 802.3 clause-22 MDIO frame and issues it to the downstream MDIO shift engine.
- Tracks the engine's read/write done handshake and writes the result back into MDIC: read data, Ready, Error.
- Pulses an interrupt request on completion when enabled.

Parameters:
- TIMEOUT, 4096, number of clk cycles from issue to completion before the operation is aborted with Error set.
- TW, 13, width of the timeout counter; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- reg_wr  in  1  one-cycle MDIC write strobe from the register file
- reg_wdata  in  32  MDIC write data: [15:0] DATA, [20:16] REGADD, [25:21] PHYADD, [27:26] OP, [29] I
- reg_rdata  out  32  current MDIC value: [15:0] DATA, [20:16] REGADD, [25:21] PHYADD, [27:26] OP, [28] R, [29] I, [30] E, [31] 0
- intr_o  out  1  one-cycle MDAC interrupt request
- eno  out  1  one-cycle start pulse to the shift engine
- wdatao  out  32  MDIO frame to the shift engine
- rdatai  in  16  read data from the shift engine
- rd_donei  in  1  engine read done; high when idle, low while a read runs
- wr_donei  in  1  engine write done; high when idle, low while a write runs

Behaviour:
- Reset values:
  - reg_rdata = 0x10000000 (R=1, all other fields 0).
  - intr_o = 0, eno = 0, wdatao = 0.
  - State = IDLE; timeout counter = 0.
- Frame format, built from the latched fields:
  - wdatao = {2'b01, OP[1:0], PHYADD[4:0], REGADD[4:0], 2'b10, DATA[15:0]}.
  - OP 2'b10 = read, 2'b01 = write.
  - DATA is forced to 0 for reads.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, COMPLETE.
- IDLE:
  - Accepts reg_wr only when rd_donei and wr_donei are both 1.
  - On accept: latch DATA, REGADD, PHYADD, OP and I; clear R and E.
  - Valid OP -> ISSUE.
  - OP 2'b00 or 2'b11 -> COMPLETE with E=1; no frame is issued.
  - reg_wr while either done input is 0 is dropped; MDIC is unchanged.
- ISSUE:
  - eno=1 and wdatao valid for exactly one cycle.
  - Timeout counter cleared to 0.
  - Next state WAIT_BUSY.
- WAIT_BUSY:
  - Waits for the done input selected by OP (read -> rd_donei, write -> wr_donei) to go 0, then -> WAIT_DONE.
  - The engine drops done on the clock edge after it samples eno.
- WAIT_DONE:
  - Waits for the selected done input to return to 1.
  - On that cycle, for reads, latch rdatai into DATA; rdatai is valid whenever rd_donei is 1.
  - Next state COMPLETE.
- Timeout:
  - Counter increments every cycle in WAIT_BUSY and WAIT_DONE.
  - When it reaches TIMEOUT-1: E=1, DATA unchanged, -> COMPLETE.
- COMPLETE:
  - One cycle: R=1; intr_o=1 if I=1.
  - Next state IDLE.
  - After a timeout, IDLE still blocks new commands until both done inputs are 1.
- reg_wr in any non-IDLE state: ignored; no field changes.
- Reset mid-operation: all state returns to reset values immediately. An in-flight engine frame is not tracked; the next command waits on the done inputs as above.
- Latency: reg_wr accept to eno = 1 cycle; selected done rising to R=1 = 2 cycles.

Test Plan:
- Read: reg_wr with 0x08220000; engine model drops rd_donei, returns rdatai=0x796D, raises rd_donei.
  -> eno pulses once with wdatao=0x608A0000.
  -> reg_rdata=0x08220000 while busy.
  -> reg_rdata=0x1822796D after completion; intr_o stays 0.
- Write with interrupt: reg_wr with 0x24221234.
  -> wdatao=0x508A1234; wr_donei used for the handshake.
  -> reg_rdata=0x34221234 after completion.
  -> intr_o high for exactly 1 cycle, 2 cycles after wr_donei rises.
- Illegal opcode: reg_wr with 0x0C220000.
  -> no eno.
  -> reg_rdata=0x5C220000 two cycles after reg_wr.
- Busy drop: second reg_wr with 0x04225555 during an active read.
  -> ignored; the first read completes normally and the fields are unchanged.
- Timeout: TIMEOUT=16; engine never drops rd_donei after a read command of 0x08220000.
  -> E=1 and R=1 on the 17th cycle after eno.
  -> reg_rdata=0x58220000.
- Reset mid-read: assert rst while in WAIT_DONE.
  -> reg_rdata=0x10000000; eno=0; intr_o=0 immediately.
  -> a new command is accepted only after both done inputs are 1.
